// File: rtl/stage_fd_buf_if.sv
// rtl/stage_fd_buf_if.sv - fetch/decode handshake bundle for the F->D instruction buffer
interface stage_fd_buf_if;
  logic        arm;
  logic        ValidF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        StallD;
  logic        FlushD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        StallF;
  logic [1:0]  CountD;

  modport master (
    output arm, ValidF, InstrF, PCF, PCPlus4F, StallD, FlushD,
    input  InstrD, PCD, PCPlus4D, ValidD, StallF, CountD
  );

  modport slave (
    input  arm, ValidF, InstrF, PCF, PCPlus4F, StallD, FlushD,
    output InstrD, PCD, PCPlus4D, ValidD, StallF, CountD
  );
endinterface

// File: rtl/stage_fd_buf.sv
// rtl/stage_fd_buf.sv - two-entry fetch->decode instruction buffer
// Decouples fetch from decode stalls; presents a mode-specific NOP when empty.
module stage_fd_buf #(
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  stage_fd_buf_if.slave fd
);
  localparam logic [31:0] NOP_ARM = 32'hE1A00000;
  localparam logic [31:0] NOP_RV  = 32'h00000013;

  logic [95:0] entry [DEPTH];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [95:0] head;

  // StallF comes from registered count only, so fetch sees no path from StallD/ValidF
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign push  = fd.ValidF && !full && !fd.FlushD;
  assign pop   = !empty && !fd.StallD && !fd.FlushD;
  assign head  = entry[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (fd.FlushD) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Storage needs no reset: it is only ever visible while ValidD is high
  always_ff @(posedge clk) begin
    if (push) entry[wr_ptr] <= {fd.InstrF, fd.PCF, fd.PCPlus4F};
  end

  always_comb begin
    fd.ValidD   = !empty;
    fd.StallF   = full;
    fd.CountD   = count;
    fd.InstrD   = fd.arm ? NOP_ARM : NOP_RV;
    fd.PCD      = 32'd0;
    fd.PCPlus4D = 32'd0;
    if (!empty) begin
      fd.InstrD   = head[95:64];
      fd.PCD      = head[63:32];
      fd.PCPlus4D = head[31:0];
    end
  end
endmodule

// File: tb/tb_stage_fd_buf.sv
// tb/tb_stage_fd_buf.sv - directed vector bench for stage_fd_buf
module tb_stage_fd_buf;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  stage_fd_buf_if bus();

  stage_fd_buf #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .fd  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        arm;
    logic        vf;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        sd;
    logic        fl;
    logic [1:0]  e_cnt;
    logic        e_vld;
    logic        e_stf;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic vf, input logic [31:0] ins,
                       input logic [31:0] pc, input logic sd, input logic fl);
    bus.arm      = a;
    bus.ValidF   = vf;
    bus.InstrF   = ins;
    bus.PCF      = pc;
    bus.PCPlus4F = pc + 32'd4;
    bus.StallD   = sd;
    bus.FlushD   = fl;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] cnt, input logic vld,
                         input logic stf, input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, " CountD"}, {30'd0, bus.CountD}, {30'd0, cnt});
    chk({tag, " ValidD"}, {31'd0, bus.ValidD}, {31'd0, vld});
    chk({tag, " StallF"}, {31'd0, bus.StallF}, {31'd0, stf});
    chk({tag, " InstrD"}, bus.InstrD, ins);
    chk({tag, " PCD"}, bus.PCD, pc);
    chk({tag, " PCPlus4D"}, bus.PCPlus4D, vld ? pc + 32'd4 : 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //             arm vf instr          pc     sd fl  cnt vld stf instrD         pcD
    vec[0]  = '{1'b0, 1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h00500093, 32'h100};
    vec[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h00000013, 32'h0};
    vec[2]  = '{1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'hE1A00000, 32'h0};
    vec[3]  = '{1'b0, 1'b1, 32'hAAAA0001, 32'h0,   1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 32'hAAAA0001, 32'h0};
    vec[4]  = '{1'b0, 1'b1, 32'hBBBB0002, 32'h4,   1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 32'hAAAA0001, 32'h0};
    vec[5]  = '{1'b0, 1'b1, 32'hCCCC0003, 32'h8,   1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 32'hAAAA0001, 32'h0};
    vec[6]  = '{1'b0, 1'b1, 32'hCCCC0003, 32'h8,   1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'hBBBB0002, 32'h4};
    vec[7]  = '{1'b0, 1'b1, 32'hCCCC0003, 32'h8,   1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'hCCCC0003, 32'h8};
    vec[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h00000013, 32'h0};
    vec[9]  = '{1'b0, 1'b1, 32'hDDDD0004, 32'h20,  1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 32'hDDDD0004, 32'h20};
    vec[10] = '{1'b0, 1'b1, 32'hEEEE0005, 32'h24,  1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 32'hDDDD0004, 32'h20};
    vec[11] = '{1'b0, 1'b1, 32'hFFFF0006, 32'h28,  1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h00000013, 32'h0};
    vec[12] = '{1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'hE1A00000, 32'h0};

    // reset state and combinational NOP select
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    chk_all("reset", 2'd0, 1'b0, 1'b0, 32'h00000013, 32'h0);
    bus.arm = 1'b1;
    #1;
    chk("reset arm NOP", bus.InstrD, 32'hE1A00000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i].arm, vec[i].vf, vec[i].instr, vec[i].pc, vec[i].sd, vec[i].fl);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vec[i].e_cnt, vec[i].e_vld, vec[i].e_stf,
              vec[i].e_instr, vec[i].e_pc);
    end

    // streaming across pointer wrap: push and pop every cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h12340000, 32'h200, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("stream0", 2'd1, 1'b1, 1'b0, 32'h12340000, 32'h200);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h12340000 + k, 32'h200 + 32'(4 * k), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_all($sformatf("stream%0d", k), 2'd1, 1'b1, 1'b0,
              32'h12340000 + k, 32'h200 + 32'(4 * k));
    end

    // fill, then asynchronous reset mid-cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h55550001, 32'h300, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("fill CountD", {30'd0, bus.CountD}, 32'd2);
    chk("fill StallF", {31'd0, bus.StallF}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, 1'b0, 1'b0, 32'h00000013, 32'h0);

    // first push after reset release lands on the first edge
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h77770001, 32'h400, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("post_rst", 2'd1, 1'b1, 1'b0, 32'h77770001, 32'h400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
